unidade_controle_rodadas: RTL and testbench

//   Control unit for the progressive-rounds memory game. Round r requires plays
//   for addresses 0..r; the game ends after round N_JOGADAS-1 succeeds, on a wrong

---
 rtl/unidade_controle_rodadas.sv | 136 +++++++++++++
 tb/tb_unidade_controle_rodadas.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas.sv
// Round-progressive memory game control unit: Moore FSM that owns the address,
// round and play-wait timeout counters and steers the datapath's play register.
module unidade_controle_rodadas #(
  parameter int N_JOGADAS      = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int MODO_TIMEOUT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              zeraR,
  output logic              registraR,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int TW = $clog2(TIMEOUT_CICLOS);

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    prepara        = 4'h1,
    inicia_rodada  = 4'h2,
    espera_jogada  = 4'h3,
    registra       = 4'h4,
    compara        = 4'h5,
    proxima_jogada = 4'h6,
    proxima_rodada = 4'h7,
    final_acerto   = 4'h8,
    final_erro     = 4'h9,
    final_timeout  = 4'hA
  } estado_t;

  estado_t       estado, proximo;
  logic [TW-1:0] timer;
  logic          timer_fim;
  logic          fim_endereco;
  logic          ultima_rodada;

  assign timer_fim     = (MODO_TIMEOUT != 0) && (timer == TW'(TIMEOUT_CICLOS - 1));
  assign fim_endereco  = (endereco == rodada);
  assign ultima_rodada = (rodada == ADDR_W'(N_JOGADAS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= inicial;
    else       estado <= proximo;
  end

  // Counter updates are keyed on the state being left, so the new value is
  // visible in the following state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco <= '0;
      rodada   <= '0;
      timer    <= '0;
    end else begin
      timer <= (estado == espera_jogada) ? timer + 1'b1 : '0;
      case (estado)
        prepara: begin
          endereco <= '0;
          rodada   <= '0;
        end
        inicia_rodada:  endereco <= '0;
        proxima_jogada: endereco <= endereco + 1'b1;
        proxima_rodada: rodada   <= rodada + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    proximo   = estado;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    db_estado = estado;
    case (estado)
      inicial: begin
        zeraR   = 1'b1;
        proximo = iniciar ? prepara : inicial;
      end
      prepara: begin
        zeraR   = 1'b1;
        proximo = inicia_rodada;
      end
      inicia_rodada: proximo = espera_jogada;
      espera_jogada: begin
        if (jogada)         proximo = registra;
        else if (timer_fim) proximo = final_timeout;
        else                proximo = espera_jogada;
      end
      registra: begin
        registraR = 1'b1;
        proximo   = compara;
      end
      compara: begin
        if (!igual)             proximo = final_erro;
        else if (!fim_endereco) proximo = proxima_jogada;
        else if (ultima_rodada) proximo = final_acerto;
        else                    proximo = proxima_rodada;
      end
      proxima_jogada: proximo = espera_jogada;
      proxima_rodada: proximo = inicia_rodada;
      final_acerto: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        proximo = iniciar ? prepara : final_acerto;
      end
      final_erro: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        proximo = iniciar ? prepara : final_erro;
      end
      final_timeout: begin
        pronto  = 1'b1;
        timeout = 1'b1;
        proximo = iniciar ? prepara : final_timeout;
      end
      default: begin
        db_estado = '1;
        proximo   = inicial;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas: randomized games scored against a
// round/address game model, plus timeout, wait-forever and async reset cases.
module tb_unidade_controle_rodadas;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int T  = 8;

  logic          clock = 1'b0;
  logic          reset, iniciar, jogada, igual;
  logic [AW-1:0] end_a, rod_a, end_b, rod_b;
  logic          zr_a, rr_a, ac_a, er_a, to_a, pr_a;
  logic          zr_b, rr_b, ac_b, er_b, to_b, pr_b;
  logic [3:0]    db_a, db_b;

  int checks = 0;
  int errors = 0;

  unidade_controle_rodadas #(.N_JOGADAS(N), .ADDR_W(AW), .TIMEOUT_CICLOS(T), .MODO_TIMEOUT(1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .endereco(end_a), .rodada(rod_a), .zeraR(zr_a), .registraR(rr_a), .acertou(ac_a),
    .errou(er_a), .timeout(to_a), .pronto(pr_a), .db_estado(db_a));

  // Same stimulus, but waits forever for a play.
  unidade_controle_rodadas #(.N_JOGADAS(N), .ADDR_W(AW), .TIMEOUT_CICLOS(T), .MODO_TIMEOUT(0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .endereco(end_b), .rodada(rod_b), .zeraR(zr_b), .registraR(rr_b), .acertou(ac_b),
    .errou(er_b), .timeout(to_b), .pronto(pr_b), .db_estado(db_b));

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {zeraR, registraR, acertou, errou, timeout, pronto} implied by a state code
  function automatic logic [5:0] flags(input int st);
    return {st <= 1, st == 4, st == 8, st == 9, st == 10, (st >= 8) && (st <= 10)};
  endfunction

  task automatic chk_out(input string tag, input int st, input int stb, input int e, input int r);
    chk({tag, ".estado"}, db_a, st);
    chk({tag, ".estado0"}, db_b, stb);
    chk({tag, ".flags"}, {zr_a, rr_a, ac_a, er_a, to_a, pr_a}, flags(st));
    chk({tag, ".endereco"}, end_a, e);
    chk({tag, ".rodada"}, rod_a, r);
  endtask

  task automatic do_reset();
    step();
    #2 reset = 1'b1;
    #1 chk_out("reset_async", 0, 0, 0, 0);
    step();
    reset = 1'b0;
  endtask

  // From inicial or a final state: iniciar seen at k -> espera_jogada at k+3.
  task automatic start_game(input int pe, input int pr);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk_out("prepara", 1, 1, pe, pr);
    step();
    chk_out("inicia_rodada", 2, 2, 0, 0);
    step();
    chk_out("espera_first", 3, 3, 0, 0);
  endtask

  // Called in the first espera_jogada cycle; jogada is raised d cycles later.
  task automatic play_one(input int r, input int a, input bit ok, input int d);
    repeat (d) step();
    chk_out("espera_pre", 3, 3, a, r);
    jogada = 1'b1;
    igual  = ok;
    step();
    jogada = 1'b0;
    chk_out("registra", 4, 4, a, r);
    step();
    chk_out("compara", 5, 5, a, r);
    step();
    if (!ok) begin
      chk_out("final_erro", 9, 9, a, r);
    end else if (a != r) begin
      chk_out("proxima_jogada", 6, 6, a, r);
      step();
      chk_out("espera_next", 3, 3, a + 1, r);
    end else if (r == N - 1) begin
      chk_out("final_acerto", 8, 8, a, r);
    end else begin
      chk_out("proxima_rodada", 7, 7, a, r);
      step();
      chk_out("inicia_next", 2, 2, a, r + 1);
      step();
      chk_out("espera_round", 3, 3, 0, r + 1);
    end
  endtask

  // Game model: round r needs plays for addresses 0..r; the play at (wr,wa)
  // is wrong; reaching (ab_r,ab_a) fires an async reset instead of playing.
  task automatic run_game(input int wr, input int wa, input int fd, input int ab_r, input int ab_a,
                          input int pe, input int pr, output int le, output int lr);
    start_game(pe, pr);
    for (int r = 0; r < N; r++) begin
      for (int a = 0; a <= r; a++) begin
        if (r == ab_r && a == ab_a) begin
          #2 reset = 1'b1;
          #1 chk_out("reset_midgame", 0, 0, 0, 0);
          step();
          chk_out("reset_hold", 0, 0, 0, 0);
          reset = 1'b0;
          step();
          chk_out("after_reset", 0, 0, 0, 0);
          le = 0;
          lr = 0;
          return;
        end
        play_one(r, a, !(r == wr && a == wa), (fd >= 0) ? fd : int'($urandom_range(7, 0)));
        if (r == wr && a == wa) begin
          repeat (3) step();
          chk_out("erro_hold", 9, 9, a, r);
          le = a;
          lr = r;
          return;
        end
      end
    end
    repeat (3) step();
    chk_out("acerto_hold", 8, 8, N - 1, N - 1);
    le = N - 1;
    lr = N - 1;
  endtask

  initial begin
    int le, lr, wr, wa, bad_a, bad_b;
    reset   = 1'b1;
    iniciar = 1'b0;
    jogada  = 1'b0;
    igual   = 1'b0;
    repeat (2) step();
    chk_out("reset", 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) step();
    chk_out("idle_inicial", 0, 0, 0, 0);

    run_game(-1, -1, -1, -1, -1, 0, 0, le, lr);
    run_game(2, 1, -1, -1, -1, le, lr, le, lr);
    run_game(-1, -1, 7, -1, -1, le, lr, le, lr);

    for (int g = 0; g < 6; g++) begin
      if ($urandom_range(2, 0) == 0) begin
        wr = -1;
        wa = -1;
      end else begin
        wr = int'($urandom_range(N - 1, 0));
        wa = int'($urandom_range(wr, 0));
      end
      run_game(wr, wa, -1, -1, -1, le, lr, le, lr);
    end

    run_game(-1, -1, -1, 2, 1, le, lr, le, lr);

    start_game(0, 0);
    repeat (T - 1) step();
    chk_out("espera_t7", 3, 3, 0, 0);
    step();
    chk_out("timeout_t8", 10, 3, 0, 0);
    chk("modo0.timeout", to_b, 0);
    bad_a = 0;
    bad_b = 0;
    repeat (1000) begin
      step();
      if (db_a !== 4'hA) bad_a++;
      if (db_b !== 4'h3) bad_b++;
    end
    chk("timeout_hold_cycles", bad_a, 0);
    chk("modo0_idle_cycles", bad_b, 0);

    do_reset();
    step();
    chk_out("final_idle", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
